alu_share_arbiter: RTL

Shares the single combinational 32-bit ALU (and/or/add/sub/slt/nor) between two requesters, e.g. two issue slots. It performs round-robin arbitration with valid/ready handshakes on every side and drives the shared ALU operands and control code. It captures each result into a one-entry response register tagged with the requester id, and patches two ALU corner cases so consumers always see a defined result.

---
 rtl/alu_share_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational ALU between two requesters using round-robin
// arbitration. The granted operation is steered onto the ALU. Its result is
// captured into a one-entry response register, tagged with the requester id.
// Two ALU corner cases are patched so the consumer always sees a defined
// result: slt with equal operands, and unsupported control codes.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   reqN_valid / reqN_ready     per-requester handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_ctrl   per-requester operands and ALU control code
//   alu_in1, alu_in2, alu_ctrl  drive to the shared ALU
//   alu_out, alu_zero           combinational result from the shared ALU
//   rsp_valid / rsp_ready       response handshake
//   rsp_id                      requester that issued the response
//   rsp_data, rsp_zero          result and its zero flag
//   rsp_err                     operation used an unsupported control code
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_ctrl,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_ctrl,

   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_err
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state;
   logic             last_grant;

   logic             can_issue;
   logic             pick1;
   logic             gnt0;
   logic             gnt1;
   logic             any_gnt;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [3:0]       sel_ctrl;
   logic             supported;
   logic             slt_eq;

   // A full register can be refilled in the same cycle it drains.
   assign can_issue = (state == EMPTY) || rsp_ready;

   // Requester 1 wins when it is alone, or when both contend and
   // requester 0 took the previous grant.
   assign pick1 = req1_valid && (!req0_valid || (last_grant == 1'b0));

   // Ready is suppressed during reset so no handshake can complete
   // while the state is being cleared.
   assign gnt1    = !reset && can_issue && pick1;
   assign gnt0    = !reset && can_issue && req0_valid && !pick1;
   assign any_gnt = gnt0 || gnt1;

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign sel_a    = gnt1 ? req1_a    : req0_a;
   assign sel_b    = gnt1 ? req1_b    : req0_b;
   assign sel_ctrl = gnt1 ? req1_ctrl : req0_ctrl;

   // With no grant, park the ALU on 0 + 0 so its output is deterministic
   // and never reflects a requester's stale operands.
   always_comb begin
      alu_in1  = '0;
      alu_in2  = '0;
      alu_ctrl = OP_ADD;
      if (any_gnt) begin
         alu_in1  = sel_a;
         alu_in2  = sel_b;
         alu_ctrl = sel_ctrl;
      end
   end

   always_comb begin
      supported = 1'b0;
      case (sel_ctrl)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: supported = 1'b1;
         default:                                       supported = 1'b0;
      endcase
   end

   // The ALU's slt result is not trusted for equal operands.
   assign slt_eq = (sel_ctrl == OP_SLT) && (sel_a == sel_b);

   // Response register FSM. The state doubles as rsp_valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         last_grant <= 1'b1;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         if (any_gnt) begin
            last_grant <= gnt1;
            rsp_id     <= gnt1;
            if (!supported) begin
               rsp_data <= '0;
               rsp_zero <= 1'b1;
               rsp_err  <= 1'b1;
            end else if (slt_eq) begin
               rsp_data <= '0;
               rsp_zero <= 1'b1;
               rsp_err  <= 1'b0;
            end else begin
               rsp_data <= alu_out;
               rsp_zero <= alu_zero;
               rsp_err  <= 1'b0;
            end
         end
         case (state)
            EMPTY:   if (any_gnt) state <= FULL;
            FULL:    if (rsp_ready && !any_gnt) state <= EMPTY;
            default: state <= EMPTY;
         endcase
      end
   end

   assign rsp_valid = (state == FULL);

endmodule
